// File: rtl/magia_pkg.sv
// Shared MAGIA tile types.
// Boot controller states and defaults.
package magia_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENABLE = 3'd1,
    RUN    = 3'd2,
    SLEEP  = 3'd3,
    WAKE   = 3'd4,
    DRAIN  = 3'd5,
    OFF    = 3'd6
  } tile_boot_state_e;

  localparam int TILE_BOOT_SETTLE_DEFAULT = 8;

endpackage

// File: rtl/magia_wu_pend.sv
// Wake-event pending register.
// New events win over a coinciding clear.
module magia_wu_pend #(
  parameter int N_WU_SRC = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_en_i,
  input  logic                clr_i,
  input  logic [N_WU_SRC-1:0] src_i,
  input  logic [N_WU_SRC-1:0] mask_i,
  output logic [N_WU_SRC-1:0] pend_o
);

  logic [N_WU_SRC-1:0] set_bits;

  assign set_bits = set_en_i ? (src_i & mask_i) : '0;

  // accumulate enabled events; clear keeps only this cycle's arrivals
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_o <= '0;
    end else if (clr_i) begin
      pend_o <= set_bits;
    end else begin
      pend_o <= pend_o | set_bits;
    end
  end

endmodule

// File: rtl/magia_tile_boot_ctrl.sv
// MAGIA tile boot/run/sleep/shutdown sequencer.
// Drives enable, boot address, fetch enable and wake pulses.
module magia_tile_boot_ctrl
  import magia_pkg::*;
#(
  parameter int SETTLE_CYC = TILE_BOOT_SETTLE_DEFAULT,
  parameter int N_WU_SRC   = 4,
  parameter int DRAIN_TO   = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [31:0]         boot_addr_cfg_i,
  input  logic [N_WU_SRC-1:0] wu_src_i,
  input  logic [N_WU_SRC-1:0] wu_mask_i,
  input  logic                core_sleep_i,
  output logic                tile_enable_o,
  output logic [31:0]         boot_addr_o,
  output logic                fetch_enable_o,
  output logic                wu_wfe_o,
  output logic                busy_o,
  output logic [2:0]          state_o,
  output logic                err_o
);

  localparam int CMAX = (SETTLE_CYC > DRAIN_TO) ? SETTLE_CYC : DRAIN_TO;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] DRAIN_LAST  =
    CW'((DRAIN_TO == 0) ? 0 : DRAIN_TO - 1);

  tile_boot_state_e    state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_d;
  logic                start_acc;
  logic                pend_set, pend_clr;
  logic [N_WU_SRC-1:0] pend;

  assign start_acc = (state_q == IDLE) && start_i;
  assign state_o   = state_q;

  magia_wu_pend #(
    .N_WU_SRC (N_WU_SRC)
  ) u_pend (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_en_i (pend_set),
    .clr_i    (pend_clr),
    .src_i    (wu_src_i),
    .mask_i   (wu_mask_i),
    .pend_o   (pend)
  );

  // next state, pending control, error and shared counter
  always_comb begin
    state_d  = state_q;
    err_d    = err_o;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = ENABLE;
          err_d    = 1'b0;
          pend_clr = 1'b1;
        end
      end
      ENABLE: begin
        if (cnt_q == SETTLE_LAST) state_d = RUN;
      end
      RUN: begin
        pend_set = 1'b1;
        if (stop_i) state_d = DRAIN;
        else if (core_sleep_i) state_d = SLEEP;
      end
      SLEEP: begin
        pend_set = 1'b1;
        if (stop_i) begin
          state_d = DRAIN;
        end else if (|pend) begin
          state_d  = WAKE;
          pend_clr = 1'b1;
        end else if (!core_sleep_i) begin
          state_d = RUN;
        end
      end
      WAKE: state_d = RUN;
      DRAIN: begin
        if (core_sleep_i) begin
          state_d = OFF;
        end else if (DRAIN_TO != 0 && cnt_q == DRAIN_LAST) begin
          state_d = OFF;
          err_d   = 1'b1;
        end
      end
      OFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q || !(state_q inside {ENABLE, DRAIN})) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // state, counter and registered tile-side outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tile_enable_o  <= 1'b0;
      fetch_enable_o <= 1'b0;
      wu_wfe_o       <= 1'b0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
      boot_addr_o    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tile_enable_o  <= state_d inside {ENABLE, RUN, SLEEP, WAKE, DRAIN};
      fetch_enable_o <= state_d inside {RUN, SLEEP, WAKE};
      wu_wfe_o       <= (state_d == WAKE);
      busy_o         <= (state_d != IDLE);
      err_o          <= err_d;
      if (start_acc) boot_addr_o <= boot_addr_cfg_i;
    end
  end

endmodule

// File: tb/tb_magia_tile_boot_ctrl.sv
// Bench for magia_tile_boot_ctrl.
// Directed vectors plus a cycle model compared every cycle.
module tb_magia_tile_boot_ctrl;

  localparam int SETTLE = 8;
  localparam int DTO    = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        core_sleep = 1'b0;
  logic [31:0] cfg = '0;
  logic [3:0]  src = '0;
  logic [3:0]  mask = '0;

  logic        tile_enable_o;
  logic [31:0] boot_addr_o;
  logic        fetch_enable_o;
  logic        wu_wfe_o;
  logic        busy_o;
  logic [2:0]  state_o;
  logic        err_o;

  always #5 clk = ~clk;

  magia_tile_boot_ctrl #(
    .SETTLE_CYC (SETTLE),
    .N_WU_SRC   (4),
    .DRAIN_TO   (DTO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stop_i          (stop),
    .boot_addr_cfg_i (cfg),
    .wu_src_i        (src),
    .wu_mask_i       (mask),
    .core_sleep_i    (core_sleep),
    .tile_enable_o   (tile_enable_o),
    .boot_addr_o     (boot_addr_o),
    .fetch_enable_o  (fetch_enable_o),
    .wu_wfe_o        (wu_wfe_o),
    .busy_o          (busy_o),
    .state_o         (state_o),
    .err_o           (err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // behavioural model: tile power, boot timer, drain age, pending events
  bit          m_en = 0, m_off = 0, m_fetch = 0, m_wfe = 0;
  bit          m_err = 0, m_sleep = 0, m_drain = 0;
  int          m_settle = 0, m_age = 0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_pend = '0;

  function automatic int m_state();
    if (m_off) return 6;
    if (!m_en) return 0;
    if (m_settle > 0) return 1;
    if (m_wfe) return 4;
    if (m_drain) return 5;
    if (m_sleep) return 3;
    return 2;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [3:0] ev;
    ev = src & mask;
    if (rst) begin
      m_en = 0; m_off = 0; m_fetch = 0; m_wfe = 0;
      m_err = 0; m_sleep = 0; m_drain = 0;
      m_settle = 0; m_age = 0; m_addr = '0; m_pend = '0;
    end else if (m_off) begin
      m_off = 0;
    end else if (!m_en) begin
      if (start) begin
        m_en = 1; m_addr = cfg; m_err = 0;
        m_pend = '0; m_settle = SETTLE;
      end
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) m_fetch = 1;
    end else if (m_wfe) begin
      m_wfe = 0;
    end else if (m_drain) begin
      m_age++;
      if (core_sleep || (DTO != 0 && m_age == DTO)) begin
        if (!core_sleep) m_err = 1;
        m_drain = 0; m_en = 0; m_off = 1;
      end
    end else begin
      if (stop) begin
        m_drain = 1; m_age = 0; m_fetch = 0; m_sleep = 0;
        m_pend = m_pend | ev;
      end else if (m_sleep && m_pend != 0) begin
        m_wfe = 1; m_sleep = 0; m_pend = ev;
      end else begin
        m_pend = m_pend | ev;
        m_sleep = core_sleep;
      end
    end
  end

  // compare DUT against the model every cycle
  always @(posedge clk) begin
    #2;
    chk("m_tile_enable", 32'(tile_enable_o), 32'(m_en));
    chk("m_fetch", 32'(fetch_enable_o), 32'(m_fetch));
    chk("m_wfe", 32'(wu_wfe_o), 32'(m_wfe));
    chk("m_busy", 32'(busy_o), 32'(m_en | m_off));
    chk("m_state", 32'(state_o), m_state());
    chk("m_err", 32'(err_o), 32'(m_err));
    chk("m_addr", boot_addr_o, m_addr);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // count edges from now until fetch_enable rises
  task automatic wait_fetch(output int n);
    n = 0;
    while (!fetch_enable_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // drive a start pulse at a negedge; returns just after the edge
  task automatic do_start(input logic [31:0] a);
    @(negedge clk);
    cfg = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n, first, seen;

    // reset state
    tick(2);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_en", 32'(tile_enable_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_addr", boot_addr_o, 0);
    rst = 1'b0;
    tick(2);

    // 1: boot
    do_start(32'hCC00_0080);
    chk("t1_en", 32'(tile_enable_o), 1);
    chk("t1_state", 32'(state_o), 1);
    wait_fetch(n);
    chk("t1_settle", n, 8);
    chk("t1_addr", boot_addr_o, 32'hCC00_0080);
    do_start(32'h1111_1111);
    tick(2);
    chk("t1_addr_hold", boot_addr_o, 32'hCC00_0080);
    chk("t1_run", 32'(state_o), 2);

    // 2: sleep then masked-in event
    mask = 4'b0010;
    core_sleep = 1'b1;
    tick(3);
    chk("t2_sleep", 32'(state_o), 3);
    src = 4'b0010;
    first = 0; seen = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) src = '0;
      if (wu_wfe_o) begin
        seen++;
        if (first == 0) first = i;
      end
    end
    chk("t2_lat", first, 2);
    chk("t2_pulses", seen, 1);
    chk("t2_resleep", 32'(state_o), 3);
    tick;
    core_sleep = 1'b0;
    tick(2);
    chk("t2_run", 32'(state_o), 2);

    // 3: event while running, masked-out source
    mask = 4'b0001;
    src = 4'b1001;
    tick;
    src = '0;
    tick(19);
    core_sleep = 1'b1;
    first = 0; seen = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (wu_wfe_o) begin
        seen++;
        if (first == 0) first = i;
      end
    end
    chk("t3_lat", first, 2);
    chk("t3_pulses", seen, 1);
    tick;
    src = 4'b1000;
    tick;
    src = '0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (wu_wfe_o) seen++;
    end
    chk("t3_masked", seen, 0);
    chk("t3_sleep", 32'(state_o), 3);

    // 4: stop beats pending wake
    src = 4'b0001;
    tick;
    src = '0;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("t4_drain", 32'(state_o), 5);
    chk("t4_fetch", 32'(fetch_enable_o), 0);
    seen = 32'(wu_wfe_o);
    @(posedge clk); #1;
    chk("t4_off", 32'(state_o), 6);
    chk("t4_en", 32'(tile_enable_o), 0);
    seen += 32'(wu_wfe_o);
    @(posedge clk); #1;
    chk("t4_idle", 32'(state_o), 0);
    chk("t4_err", 32'(err_o), 0);
    chk("t4_nowake", seen, 0);

    // 5: drain timeout
    core_sleep = 1'b0;
    do_start(32'h8000_0000);
    wait_fetch(n);
    @(negedge clk);
    stop = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      if (n == 0) stop = 1'b0;
      n++;
    end while (tile_enable_o && n < 400);
    chk("t5_timeout", n, 257);
    chk("t5_err", 32'(err_o), 1);
    tick(5);
    chk("t5_sticky", 32'(err_o), 1);
    chk("t5_idle", 32'(state_o), 0);
    do_start(32'h8000_0000);
    chk("t5_errclr", 32'(err_o), 0);

    // 6: reset mid-drain
    wait_fetch(n);
    @(negedge clk);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    tick(10);
    chk("t6_drain", 32'(state_o), 5);
    rst = 1'b1;
    #1;
    chk("t6_state", 32'(state_o), 0);
    chk("t6_en", 32'(tile_enable_o), 0);
    chk("t6_fetch", 32'(fetch_enable_o), 0);
    chk("t6_busy", 32'(busy_o), 0);
    chk("t6_addr", boot_addr_o, 0);
    tick;
    rst = 1'b0;
    tick;
    do_start(32'h1234_5678);
    chk("t6_boot", 32'(tile_enable_o), 1);
    wait_fetch(n);
    chk("t6_settle", n, 8);
    chk("t6_addr2", boot_addr_o, 32'h1234_5678);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
